// File: rtl/char_stream_reader.sv
// char_stream_reader
// Walks the character buffer from index 0 after a START pulse. It presents each
// character to the glyph engine over a valid/accept handshake. The pass ends on
// the first NUL or after the last slot, and READ_DONE then pulses for one cycle.
//
// Optional build macro: CHAR_READER_SKIP_CTRL_EN
//   When it is defined, control bytes 0x01-0x1F (all except newline 0x0A) are
//   skipped silently in FETCH. They are neither presented nor counted.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   START          in   one-cycle pulse that begins a pass from index 0
//   curr_character in   buffer data for the current index (combinational)
//   CHAR_ACCEPT    in   downstream takes CHAR_OUT this cycle
//   index          out  buffer read address
//   CHAR_OUT       out  registered character presented downstream
//   CHAR_VALID     out  CHAR_OUT is valid
//   BUSY           out  FSM is not in IDLE (registered)
//   READ_DONE      out  one-cycle pulse at the end of a pass
//   CHAR_COUNT     out  characters accepted in the current or last pass (saturates at 255)
module char_stream_reader #(
  parameter int unsigned DEPTH       = 100,
  parameter int unsigned INDEX_WIDTH = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   START,
  input  logic [7:0]             curr_character,
  input  logic                   CHAR_ACCEPT,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [7:0]             CHAR_OUT,
  output logic                   CHAR_VALID,
  output logic                   BUSY,
  output logic                   READ_DONE,
  output logic [7:0]             CHAR_COUNT
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(DEPTH - 1);
  localparam logic [7:0]             COUNT_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   skip_c;

  // Decides whether the byte being fetched is a control byte to drop.
`ifdef CHAR_READER_SKIP_CTRL_EN
  assign skip_c = (curr_character >= 8'h01) && (curr_character <= 8'h1F) &&
                  (curr_character != 8'h0A);
`else
  assign skip_c = 1'b0;
`endif

  // Read-pass FSM. All outputs are registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      CHAR_OUT   <= 8'h00;
      CHAR_VALID <= 1'b0;
      BUSY       <= 1'b0;
      READ_DONE  <= 1'b0;
      CHAR_COUNT <= 8'h00;
    end else begin
      READ_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            index      <= '0;
            CHAR_COUNT <= 8'h00;
            BUSY       <= 1'b1;
            state      <= FETCH;
          end
        end

        FETCH: begin
          if (curr_character == 8'h00) begin
            READ_DONE <= 1'b1;
            state     <= DONE;
          end else if (skip_c) begin
            // A skipped byte at the last slot still ends the pass without wrapping.
            if (index == LAST_INDEX) begin
              READ_DONE <= 1'b1;
              state     <= DONE;
            end else begin
              index <= index + INDEX_WIDTH'(1);
            end
          end else begin
            CHAR_OUT   <= curr_character;
            CHAR_VALID <= 1'b1;
            state      <= PRESENT;
          end
        end

        PRESENT: begin
          if (CHAR_ACCEPT) begin
            CHAR_VALID <= 1'b0;
            if (CHAR_COUNT != COUNT_MAX) begin
              CHAR_COUNT <= CHAR_COUNT + 8'd1;
            end
            if (index == LAST_INDEX) begin
              READ_DONE <= 1'b1;
              state     <= DONE;
            end else begin
              index <= index + INDEX_WIDTH'(1);
              state <= FETCH;
            end
          end
        end

        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_reader.sv
// Testbench for char_stream_reader. It models the buffer as an array that
// feeds curr_character. A reference model builds the expected character
// stream from the buffer contents. A monitor checks each accepted character
// against that model.
module tb_char_stream_reader;

  localparam int unsigned DEPTH       = 100;
  localparam int unsigned INDEX_WIDTH = 7;

  logic                   clock;
  logic                   reset;
  logic                   START;
  logic [7:0]             curr_character;
  logic                   CHAR_ACCEPT;
  logic [INDEX_WIDTH-1:0] index;
  logic [7:0]             CHAR_OUT;
  logic                   CHAR_VALID;
  logic                   BUSY;
  logic                   READ_DONE;
  logic [7:0]             CHAR_COUNT;

  char_stream_reader #(.DEPTH(DEPTH), .INDEX_WIDTH(INDEX_WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .START          (START),
    .curr_character (curr_character),
    .CHAR_ACCEPT    (CHAR_ACCEPT),
    .index          (index),
    .CHAR_OUT       (CHAR_OUT),
    .CHAR_VALID     (CHAR_VALID),
    .BUSY           (BUSY),
    .READ_DONE      (READ_DONE),
    .CHAR_COUNT     (CHAR_COUNT)
  );

  // Buffer store: slots at DEPTH and above are never read but exist so any index is legal.
  logic [7:0] mem [128];
  assign curr_character = mem[index];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [7:0] ch;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   exp_total;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   accepts  = 0;
  int   valid_cycles = 0;
  int   done_count   = 0;
  int   done_cycle   = 0;
  int   last_accept_cycle = 0;
  int   accept_mode  = 0;  // 0: always accept, 1: random, 2: hold off
  int   start_cyc    = 0;
  int   accepts0, done0, valid0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit skipped(input logic [7:0] c);
`ifdef CHAR_READER_SKIP_CTRL_EN
    return (c >= 8'h01) && (c <= 8'h1F) && (c != 8'h0A);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the bytes the plotter should receive, in order.
  task automatic build_expected();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem[i] == 8'h00) break;
      if (skipped(mem[i])) continue;
      e.ch  = mem[i];
      e.idx = i;
      exp_q.push_back(e);
    end
    exp_total = exp_q.size();
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Drives the downstream accept.
  always @(posedge clock) begin
    #1;
    case (accept_mode)
      0:       CHAR_ACCEPT = 1'b1;
      1:       CHAR_ACCEPT = 1'($urandom_range(0, 1));
      default: CHAR_ACCEPT = 1'b0;
    endcase
  end

  // Monitor: compares each handshake against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (CHAR_VALID && CHAR_ACCEPT) begin
        if (exp_q.size() == 0) begin
          check("unexpected_char", 32'(CHAR_OUT), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("char_out", 32'(CHAR_OUT), 32'(e.ch));
          check("char_index", 32'(index), 32'(e.idx));
        end
        accepts++;
        last_accept_cycle = cyc;
      end
      if (CHAR_VALID) valid_cycles++;
      if (READ_DONE) begin
        done_count++;
        done_cycle = cyc;
      end
    end
  end

  task automatic start_pass();
    build_expected();
    accepts0 = accepts;
    done0    = done_count;
    valid0   = valid_cycles;
    @(posedge clock);
    #1 START = 1'b1;
    start_cyc = cyc;
    @(posedge clock);
    #1 START = 1'b0;
  endtask

  // Waits for READ_DONE and checks the final pass state. A START pulse may be injected mid-pass.
  task automatic finish_pass(input int budget, input bit inject, input int exp_lat);
    int n = 0;
    int k = int'($urandom_range(1, 6));
    while (done_count == done0 && n < budget) begin
      @(posedge clock);
      #1 START = inject && (n == k);
      n++;
    end
    START = 1'b0;
    if (done_count == done0) begin
      check("done_timeout", 32'(n), 32'(budget + 1));
      return;
    end
    @(posedge clock);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("accept_total", 32'(accepts - accepts0), 32'(exp_total));
    check("char_count", 32'(CHAR_COUNT), 32'(exp_total > 255 ? 255 : exp_total));
    check("busy_after_done", 32'(BUSY), 32'd0);
    if (exp_lat >= 0)
      check("done_latency", 32'(done_cycle - last_accept_cycle), 32'(exp_lat));
    // Any START that landed in DONE must not have begun a new pass.
    repeat (3) @(posedge clock);
    #2;
    check("idle_after_pass", 32'({BUSY, CHAR_VALID}), 32'd0);
    check("single_done", 32'(done_count - done0), 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    START = 1'b0;
    CHAR_ACCEPT = 1'b0;
    clear_mem();
    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs", 32'({index, CHAR_OUT, CHAR_VALID, BUSY, READ_DONE, CHAR_COUNT}), 32'd0);
    @(negedge clock) reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("idle_hold", 32'({BUSY, CHAR_VALID, READ_DONE}), 32'd0);

    // "HI\0" with accept held high.
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h49;
    accept_mode = 0;
    start_pass();
    finish_pass(200, 1'b0, 2);
    check("hi_valid_cycles", 32'(valid_cycles - valid0), 32'd2);

    // Backpressure: "A\0" held off for 10 cycles.
    clear_mem();
    mem[0] = 8'h41;
    accept_mode = 2;
    start_pass();
    begin
      int n = 0;
      while (!CHAR_VALID && n < 10) begin @(posedge clock); #2; n++; end
      check("bp_valid_rise", 32'(CHAR_VALID), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_stable", 32'({CHAR_VALID, CHAR_OUT}), 32'h141);
      @(posedge clock);
      #2;
    end
    accept_mode = 0;
    finish_pass(200, 1'b0, 2);

    // Empty buffer.
    clear_mem();
    start_pass();
    finish_pass(50, 1'b0, -1);
    check("empty_done_latency", 32'(done_cycle - start_cyc), 32'd2);
    check("empty_no_valid", 32'(valid_cycles - valid0), 32'd0);

    // Full buffer with no NUL.
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'h2A;
    accept_mode = 1;
    start_pass();
    finish_pass(3000, 1'b1, 1);
    check("full_last_index", 32'(index), 32'(DEPTH - 1));

    // Reset while presenting index 5, then a clean restart.
    clear_mem();
    for (int i = 0; i < 30; i++) mem[i] = 8'($urandom_range(32, 126));
    accept_mode = 0;
    start_pass();
    begin
      int n = 0;
      while (!(CHAR_VALID && index == 7'd5) && n < 50) begin @(posedge clock); #2; n++; end
      check("reach_index5", 32'({CHAR_VALID, index}), 32'h85);
    end
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", 32'({index, CHAR_OUT, CHAR_VALID, BUSY, READ_DONE, CHAR_COUNT}), 32'd0);
    exp_q.delete();
    @(negedge clock) reset = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    check("no_done_after_reset", 32'(done_count - done0), 32'd0);
    start_pass();
    finish_pass(500, 1'b0, 2);

    // Control-byte handling.
    clear_mem();
    mem[0] = 8'h41; mem[1] = 8'h09; mem[2] = 8'h0A; mem[3] = 8'h42;
    start_pass();
    finish_pass(200, 1'b0, 2);
`ifdef CHAR_READER_SKIP_CTRL_EN
    check("ctrl_count", 32'(CHAR_COUNT), 32'd3);
`else
    check("ctrl_count", 32'(CHAR_COUNT), 32'd4);
`endif

    // Random buffers, random accept, stray START pulses.
    accept_mode = 1;
    for (int t = 0; t < 8; t++) begin
      int nul_pos = int'($urandom_range(0, 110));
      for (int i = 0; i < 128; i++) begin
        if (i >= int'(DEPTH) || i == nul_pos) mem[i] = 8'h00;
        else if ($urandom_range(0, 3) == 0) mem[i] = 8'($urandom_range(1, 31));
        else mem[i] = 8'($urandom_range(32, 255));
      end
      start_pass();
      finish_pass(3000, 1'b1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
